// File: rtl/conv2d_pkg.sv
// Shared types and default geometry for the conv2d memory server and its memories.
// Geometry defaults here feed the top-level parameters.
package conv2d_pkg;

  localparam int DW = 16;
  localparam int R  = 3;
  localparam int H  = 32;

  typedef logic [DW-1:0] word_t;

  typedef enum logic [1:0] {
    SelWeight = 2'd0,
    SelFeat   = 2'd1,
    SelOut    = 2'd2,
    SelRsvd   = 2'd3
  } mem_sel_t;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Run  = 2'd1,
    Done = 2'd2
  } server_phase_t;

endpackage

// File: rtl/conv2d_sram_1r1w.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
// Holds the engine's output map.
module conv2d_sram_1r1w #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AWID  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AWID-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AWID-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: storage and its read register carry no reset so this maps onto a RAM macro;
  // consumers must qualify rdata_o with their own valid/select state.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv2d_mem_server.sv
// Memory-side responder for the conv2d engine: weight/feature/output storage,
// registered R-lane engine reads, engine write capture and host load/unload port.
module conv2d_mem_server #(
  parameter int DW = conv2d_pkg::DW,
  parameter int R  = conv2d_pkg::R,
  parameter int H  = conv2d_pkg::H,
  parameter int AW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            done_o,
  output logic            err_o,
  output logic            eng_start_o,
  input  logic [AW-1:0]   eng_raddr_i,
  input  logic            eng_addr_is_weight_i,
  output logic [R*DW-1:0] eng_rdata_o,
  input  logic            eng_wen_i,
  input  logic [AW-1:0]   eng_waddr_i,
  input  logic [DW-1:0]   eng_wdata_i,
  input  logic            host_valid_i,
  output logic            host_ready_o,
  input  logic            host_we_i,
  input  logic [1:0]      host_sel_i,
  input  logic [AW-1:0]   host_addr_i,
  input  logic [DW-1:0]   host_wdata_i,
  output logic            host_rvalid_o,
  output logic [DW-1:0]   host_rdata_o
);

  import conv2d_pkg::*;

  localparam int NPIX = H * H;
  localparam int NW   = R * R;
  localparam int FAW  = $clog2(NPIX);
  localparam int WAW  = $clog2(NW);
  localparam int CW   = $clog2(NPIX + 1);
  localparam int HALF = R / 2;

  server_phase_t   state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            err_q, err_d;
  logic [R*DW-1:0] lanes_q, lanes_d;
  logic            rvalid_q, rvalid_d;
  mem_sel_t        rsrc_q, rsrc_d;
  logic [DW-1:0]   hdata_q, hdata_d;

  logic            host_ready;
  logic            eng_start;
  logic            done;
  logic            host_xfer;
  logic            host_wr;
  logic            host_rd;
  mem_sel_t        host_sel;
  logic            host_in_range;
  logic [WAW-1:0]  host_widx;
  logic [FAW-1:0]  host_fidx;
  logic            eng_wr_ok;

  logic            out_we;
  logic [FAW-1:0]  out_waddr;
  logic [DW-1:0]   out_wdata;
  logic            out_re;
  logic [DW-1:0]   out_rdata;

  logic [DW-1:0]   wmem [NW];
  logic [DW-1:0]   fmem [NPIX];

  // ---------------------------------------------------------------------------
  // Host request decode
  // ---------------------------------------------------------------------------
  assign host_sel  = mem_sel_t'(host_sel_i);
  assign host_xfer = host_valid_i && host_ready;
  assign host_wr   = host_xfer && host_we_i;
  assign host_rd   = host_xfer && !host_we_i;
  assign host_widx = WAW'(host_addr_i);
  assign host_fidx = FAW'(host_addr_i);
  assign eng_wr_ok = int'(eng_waddr_i) < NPIX;

  always_comb begin
    host_in_range = 1'b0;
    case (host_sel)
      SelWeight:       host_in_range = int'(host_addr_i) < NW;
      SelFeat, SelOut: host_in_range = int'(host_addr_i) < NPIX;
      default:         host_in_range = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Phase sequencing and engine write accounting
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    eng_start  = 1'b0;
    host_ready = 1'b0;
    done       = 1'b0;
    case (state_q)
      Idle, Done: begin
        host_ready = 1'b1;
        done       = (state_q == Done);
        if (start_i) begin
          state_d   = Run;
          eng_start = 1'b1;
          wcnt_d    = '0;
          err_d     = 1'b0;
        end
      end
      Run: begin
        if (eng_wen_i) begin
          wcnt_d = wcnt_q + 1'b1;
          if (!eng_wr_ok) err_d = 1'b1;
          if (wcnt_d == CW'(NPIX)) state_d = Done;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= Idle;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      lanes_q  <= '0;
      rvalid_q <= 1'b0;
      rsrc_q   <= SelRsvd;
      hdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      lanes_q  <= lanes_d;
      rvalid_q <= rvalid_d;
      rsrc_q   <= rsrc_d;
      hdata_q  <= hdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Weight and feature storage (host-written only)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (host_wr && host_in_range && host_sel == SelWeight) wmem[host_widx] <= host_wdata_i;
    if (host_wr && host_in_range && host_sel == SelFeat)   fmem[host_fidx] <= host_wdata_i;
  end

  // ---------------------------------------------------------------------------
  // Engine R-lane read: lane r sees weight row r, or feature row (row + r - R/2)
  // with rows outside the map returning zero padding.
  // ---------------------------------------------------------------------------
  always_comb begin
    int raddr;
    int row;
    int col;
    int src;
    lanes_d = '0;
    raddr   = int'(eng_raddr_i);
    row     = raddr / H;
    col     = raddr % H;
    src     = 0;
    if (eng_addr_is_weight_i) begin
      if (raddr < R) begin
        for (int r = 0; r < R; r++) lanes_d[r*DW +: DW] = wmem[WAW'(r * R + raddr)];
      end
    end else if (raddr < NPIX) begin
      for (int r = 0; r < R; r++) begin
        src = row + r - HALF;
        if (src >= 0 && src < H) lanes_d[r*DW +: DW] = fmem[FAW'(src * H + col)];
      end
    end
  end

  assign eng_rdata_o = lanes_q;

  // ---------------------------------------------------------------------------
  // Output map: engine owns the write port during Run, the host otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_we    = 1'b0;
    out_waddr = host_fidx;
    out_wdata = host_wdata_i;
    if (state_q == Run) begin
      out_we    = eng_wen_i && eng_wr_ok;
      out_waddr = FAW'(eng_waddr_i);
      out_wdata = eng_wdata_i;
    end else begin
      out_we = host_wr && host_in_range && host_sel == SelOut;
    end
  end

  assign out_re = host_rd && host_in_range && host_sel == SelOut;

  conv2d_sram_1r1w #(
    .DEPTH (NPIX),
    .WIDTH (DW)
  ) u_out_mem (
    .clk_i   (clk_i),
    .we_i    (out_we),
    .waddr_i (out_waddr),
    .wdata_i (out_wdata),
    .re_i    (out_re),
    .raddr_i (host_fidx),
    .rdata_o (out_rdata)
  );

  // ---------------------------------------------------------------------------
  // Host read return: weight/feature words are captured here, output words come
  // from the RAM's own read register; rsrc_q remembers which one to present.
  // ---------------------------------------------------------------------------
  always_comb begin
    rvalid_d = host_rd;
    rsrc_d   = rsrc_q;
    hdata_d  = hdata_q;
    if (host_rd) begin
      rsrc_d  = host_in_range ? host_sel : SelRsvd;
      hdata_d = '0;
      if (host_in_range) begin
        case (host_sel)
          SelWeight: hdata_d = wmem[host_widx];
          SelFeat:   hdata_d = fmem[host_fidx];
          default:   hdata_d = '0;
        endcase
      end
    end
  end

  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = (rsrc_q == SelOut) ? out_rdata : hdata_q;
  assign host_ready_o  = host_ready;
  assign eng_start_o   = eng_start;
  assign done_o        = done;
  assign err_o         = err_q;

endmodule

// File: tb/tb_conv2d_mem_server.sv
// Randomised self-checking bench for conv2d_mem_server against an array-based
// reference of the three memories and the run/done phase.
module tb_conv2d_mem_server;

  localparam int DW   = 16;
  localparam int R    = 3;
  localparam int H    = 32;
  localparam int AW   = 16;
  localparam int NPIX = H * H;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            start_i = 1'b0;
  logic            done_o;
  logic            err_o;
  logic            eng_start_o;
  logic [AW-1:0]   eng_raddr_i = '0;
  logic            eng_addr_is_weight_i = 1'b0;
  logic [R*DW-1:0] eng_rdata_o;
  logic            eng_wen_i = 1'b0;
  logic [AW-1:0]   eng_waddr_i = '0;
  logic [DW-1:0]   eng_wdata_i = '0;
  logic            host_valid_i = 1'b0;
  logic            host_ready_o;
  logic            host_we_i = 1'b0;
  logic [1:0]      host_sel_i = '0;
  logic [AW-1:0]   host_addr_i = '0;
  logic [DW-1:0]   host_wdata_i = '0;
  logic            host_rvalid_o;
  logic [DW-1:0]   host_rdata_o;

  always #5 clk_i = ~clk_i;

  conv2d_mem_server #(.DW(DW), .R(R), .H(H), .AW(AW)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .start_i              (start_i),
    .done_o               (done_o),
    .err_o                (err_o),
    .eng_start_o          (eng_start_o),
    .eng_raddr_i          (eng_raddr_i),
    .eng_addr_is_weight_i (eng_addr_is_weight_i),
    .eng_rdata_o          (eng_rdata_o),
    .eng_wen_i            (eng_wen_i),
    .eng_waddr_i          (eng_waddr_i),
    .eng_wdata_i          (eng_wdata_i),
    .host_valid_i         (host_valid_i),
    .host_ready_o         (host_ready_o),
    .host_we_i            (host_we_i),
    .host_sel_i           (host_sel_i),
    .host_addr_i          (host_addr_i),
    .host_wdata_i         (host_wdata_i),
    .host_rvalid_o        (host_rvalid_o),
    .host_rdata_o         (host_rdata_o)
  );

  // Reference state: memories as plain arrays, phase 0=idle 1=run 2=done.
  logic [DW-1:0] w_m [R*R];
  logic [DW-1:0] f_m [NPIX];
  logic [DW-1:0] o_m [NPIX];
  bit            o_known [NPIX];
  int            ph = 0;
  int            cnt = 0;
  bit            err_m = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [R*DW-1:0] model_lanes(input bit is_w, input int raddr);
    logic [R*DW-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++) begin
      int row;
      row = raddr / H + r - R / 2;
      if (is_w) begin
        if (raddr < R) v[r*DW +: DW] = w_m[r*R + raddr];
      end else if (raddr < NPIX && row >= 0 && row < H) begin
        v[r*DW +: DW] = f_m[row*H + raddr % H];
      end
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] model_host(input int sel, input int addr);
    if (sel == 0 && addr < R*R) return w_m[addr];
    if (sel == 1 && addr < NPIX) return f_m[addr];
    if (sel == 2 && addr < NPIX) return o_m[addr];
    return '0;
  endfunction

  task automatic host_write(input int sel, input int addr, input int data, input bit with_start = 1'b0);
    bit acc;
    acc          = (ph != 1);
    host_valid_i = 1'b1;
    host_we_i    = 1'b1;
    host_sel_i   = sel[1:0];
    host_addr_i  = addr[AW-1:0];
    host_wdata_i = data[DW-1:0];
    start_i      = with_start;
    #1;
    check("host_ready_wr", host_ready_o, acc);
    if (with_start) check("start_pulse", eng_start_o, 1'b1);
    cyc();
    host_valid_i = 1'b0;
    host_we_i    = 1'b0;
    start_i      = 1'b0;
    if (acc) begin
      if (sel == 0 && addr < R*R) w_m[addr] = data[DW-1:0];
      if (sel == 1 && addr < NPIX) f_m[addr] = data[DW-1:0];
      if (sel == 2 && addr < NPIX) begin
        o_m[addr] = data[DW-1:0];
        o_known[addr] = 1'b1;
      end
      if (with_start) begin
        ph = 1; cnt = 0; err_m = 1'b0;
      end
    end
  endtask

  task automatic host_read(input int sel, input int addr);
    bit acc;
    logic [DW-1:0] exp;
    acc          = (ph != 1);
    exp          = model_host(sel, addr);
    host_valid_i = 1'b1;
    host_we_i    = 1'b0;
    host_sel_i   = sel[1:0];
    host_addr_i  = addr[AW-1:0];
    #1;
    check("host_ready_rd", host_ready_o, acc);
    cyc();
    host_valid_i = 1'b0;
    check("host_rvalid", host_rvalid_o, acc);
    if (acc) check($sformatf("host_rdata s%0d a%0d", sel, addr), host_rdata_o, exp);
    cyc();
    check("host_rvalid_drop", host_rvalid_o, 1'b0);
  endtask

  task automatic eng_read(input bit is_w, input int raddr);
    eng_addr_is_weight_i = is_w;
    eng_raddr_i          = raddr[AW-1:0];
    cyc();
    check($sformatf("lanes w%0d a%0d", is_w, raddr), eng_rdata_o, model_lanes(is_w, raddr));
  endtask

  task automatic eng_write(input int addr, input int data);
    eng_wen_i   = 1'b1;
    eng_waddr_i = addr[AW-1:0];
    eng_wdata_i = data[DW-1:0];
    cyc();
    eng_wen_i = 1'b0;
    if (ph == 1) begin
      cnt++;
      if (addr < NPIX) begin
        o_m[addr] = data[DW-1:0];
        o_known[addr] = 1'b1;
      end else begin
        err_m = 1'b1;
      end
      if (cnt == NPIX) ph = 2;
    end
    check("done_o", done_o, ph == 2);
    check("err_o", err_o, err_m);
    check("host_ready_o", host_ready_o, ph != 1);
  endtask

  task automatic start_run();
    start_i = 1'b1;
    #1;
    check("start_pulse", eng_start_o, 1'b1);
    cyc();
    start_i = 1'b0;
    ph = 1; cnt = 0; err_m = 1'b0;
    #1;
    check("start_single", eng_start_o, 1'b0);
    check("run_done_low", done_o, 1'b0);
    check("run_err_clr", err_o, 1'b0);
    check("run_ready_low", host_ready_o, 1'b0);
  endtask

  task automatic random_out_reads(input int n);
    for (int k = 0; k < n; k++) begin
      int a;
      a = $urandom_range(NPIX - 1);
      if (o_known[a]) host_read(2, a);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NPIX; i++) o_known[i] = 1'b0;

    repeat (3) cyc();
    rst_i = 1'b0;
    #1;
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_start", eng_start_o, 1'b0);
    check("rst_rvalid", host_rvalid_o, 1'b0);
    check("rst_rdata", host_rdata_o, '0);
    check("rst_lanes", eng_rdata_o, '0);
    check("rst_ready", host_ready_o, 1'b1);

    for (int r = 0; r < R; r++)
      for (int c = 0; c < R; c++) host_write(0, r*R + c, r*3 + c + 1);
    eng_read(1'b1, 0);
    check("w_col0_const", eng_rdata_o, {16'd7, 16'd4, 16'd1});
    eng_read(1'b1, 1);
    eng_read(1'b1, 2);
    check("w_col2_const", eng_rdata_o, {16'd9, 16'd6, 16'd3});
    eng_read(1'b1, 3);

    for (int a = 0; a < NPIX; a++) host_write(1, a, a);
    eng_read(1'b0, 0);
    check("f_top_pad", eng_rdata_o, {16'd32, 16'd0, 16'd0});
    eng_read(1'b0, 31*32 + 5);
    check("f_bot_pad", eng_rdata_o, {16'd0, 16'd997, 16'd965});
    eng_read(1'b0, NPIX);
    eng_read(1'b0, 17*32 + 31);

    for (int k = 0; k < 120; k++) begin
      int sel;
      case ($urandom_range(3))
        0: eng_read(1'b0, $urandom_range(NPIX + 40));
        1: eng_read(1'b1, $urandom_range(5));
        2: begin
          sel = $urandom_range(1);
          host_write(sel, (sel == 0) ? $urandom_range(12) : $urandom_range(NPIX + 8), $urandom);
        end
        default: begin
          sel = $urandom_range(2);
          if (sel == 2) sel = 3;
          host_read(sel, (sel == 0) ? $urandom_range(12) : $urandom_range(NPIX + 8));
        end
      endcase
    end
    host_read(3, 7);

    // Run A: host write shares the cycle with start; engine must see the new word.
    begin
      int x;
      x = $urandom_range(NPIX - 1);
      host_write(1, x, $urandom, 1'b1);
      check("runA_ready", host_ready_o, 1'b0);
      check("runA_start_single", eng_start_o, 1'b0);
      eng_read(1'b0, x);
    end
    for (int i = 0; i < NPIX; i++) begin
      if ($urandom_range(7) == 0) host_write(0, $urandom_range(8), $urandom);
      if ($urandom_range(15) == 0) host_read(1, $urandom_range(NPIX - 1));
      eng_write(i, i);
    end
    host_read(2, 100);
    check("out100_const", host_rdata_o, 16'd100);
    eng_read(1'b1, 0);
    eng_read(1'b1, 2);
    random_out_reads(20);

    // Run B: restart from Done, out-of-range write, then reset part way.
    start_run();
    for (int i = 0; i < 500; i++) eng_write((i == 200) ? NPIX : i, $urandom);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    ph = 0; cnt = 0; err_m = 1'b0;
    #1;
    check("midrst_done", done_o, 1'b0);
    check("midrst_err", err_o, 1'b0);
    check("midrst_ready", host_ready_o, 1'b1);
    host_read(2, 200);
    host_read(2, 499);
    host_read(2, 777);
    random_out_reads(20);
    eng_write(5, 16'hbeef);
    host_read(2, 5);

    // Run C: full count with the final write out of range.
    start_run();
    for (int i = 0; i < NPIX; i++) begin
      if ($urandom_range(5) == 0) cyc();
      eng_write((i == NPIX - 1) ? 2000 : i, $urandom);
    end
    check("runC_done", done_o, 1'b1);
    check("runC_err", err_o, 1'b1);
    host_read(3, 0);
    random_out_reads(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
